lagarto_plic_target: RTL and testbench
======================================

Name: lagarto_plic_target

Overview:
- Claim/complete controller for one PLIC interrupt target (hart context), fed by the JTAG0 and JTAG1 sources.
- Per-source gateways latch level requests into pending state. A priority arbiter picks the best pending, enabled source above threshold and drives the hart's external-interrupt line.
- A claim/complete handshake serialises service. Priority, enable and threshold are configured through a simple register write port.

Parameters:
- NUM_SOURCES, 2, number of interrupt sources. IDs 1..NUM_SOURCES map to JTAG0_ID and JTAG1_ID; ID 0 is NO_INTERRUPT_ID.
- All priority, threshold and ID fields are MXLEN wide, from riscv_privileged_pkg, typed as interrupt_priority_t and interrupt_id_t.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- irq_src_i  in  NUM_SOURCES  level interrupt requests; bit k-1 is ID k
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  2  0 = threshold, 1 = priority[1], 2 = priority[2], 3 = enable mask
- cfg_wdata_i  in  MXLEN  config write data
- eip_o  out  1  external interrupt pending to hart (registered)
- claim_req_i  in  1  claim request pulse
- claim_valid_o  out  1  claim response valid, one-cycle pulse
- claim_id_o  out  MXLEN  claimed ID, interrupt_id_t; 0 if none
- complete_valid_i  in  1  completion strobe
- complete_id_i  in  MXLEN  ID being completed

Behaviour:
- Reset values:
  - priority[1] = JTAG0_PRIORITY (1), priority[2] = JTAG1_PRIORITY (2).
  - threshold = NO_INTERRUPT_PRIORITY (0).
  - enable = INTERRUPT_ENABLE_MASK[NUM_SOURCES-1:0] (2'b11).
  - All gateways IDLE; best_id = 0.
  - eip_o = 0, claim_valid_o = 0, claim_id_o = 0.
- Gateway FSM per source, states IDLE / PENDING / CLAIMED:
  - IDLE -> PENDING when irq_src_i[k] = 1, latched at the next edge.
  - PENDING -> CLAIMED when a claim returns ID k.
  - CLAIMED -> IDLE on complete_valid_i with complete_id_i == k.
  - In CLAIMED, irq_src_i is ignored. If the level is still high after completion, the source re-enters PENDING on the following edge.
  - A request deasserting while PENDING does not clear PENDING.
- Arbiter:
  - Candidates are sources with PENDING && enable[k] && priority[k] > threshold, compared as unsigned full MXLEN.
  - Highest priority wins; ties go to the lowest ID. Priority 0 never wins.
  - Result is registered into best_id each cycle. eip_o <= (next best_id != 0).
  - Latency from irq_src_i rising to eip_o = 1 is 2 cycles: gateway edge, then arbiter edge.
- Claim:
  - On a cycle with claim_req_i = 1: at the next edge claim_valid_o = 1 and claim_id_o = best_id as registered at the time of the request. The selected gateway moves to CLAIMED on that same edge.
  - If best_id = 0, claim_id_o = 0 and no state changes.
  - claim_id_o holds its value until the next claim; claim_valid_o clears after one cycle.
  - Back-to-back claims are allowed. The second claim uses the updated best_id, which excludes the just-claimed source only after one arbiter cycle. Within one cycle of a claim, the arbiter masks any source being claimed so that the same ID is never returned twice.
- Complete:
  - Ignored if the ID is 0, greater than NUM_SOURCES, or not in CLAIMED.
  - Completion does not require the source to be enabled.
- Simultaneous events:
  - Claim and complete in the same cycle are both applied.
  - A config write in the same cycle as a claim takes effect for arbitration from the next cycle; the claim uses the old best_id.
- Config writes:
  - Applied at the edge where cfg_we_i = 1.
  - Enable uses cfg_wdata_i[NUM_SOURCES-1:0].
  - Disabling a PENDING source keeps it PENDING but removes it from arbitration.
- rst_i asserted mid-operation returns all state to the reset values at the next edge; any outstanding claims are discarded.

Test Plan:
- Reset, then raise irq_src_i = 2'b01 -> eip_o = 1 two cycles later; claim -> claim_valid_o = 1, claim_id_o = 1; eip_o = 0 one cycle after the claim.
- Raise both sources together -> claim returns 2 (priority 2 > 1). A second claim returns 1. A third claim returns 0 with no state change.
- Write priority[1] = 2, then raise both -> tie, claim returns 1 (lowest ID).
- Write threshold = 2 with both sources pending -> eip_o = 0, claim returns 0. Write threshold = 1 -> eip_o = 1, claim returns 2.
- Claim ID 1 while irq_src_i[0] stays high -> no re-pend while CLAIMED. Issue complete_id_i = 2 (not claimed) -> ignored. Issue complete_id_i = 1 -> PENDING next cycle, eip_o = 1 one cycle after that.
- Assert rst_i while source 2 is CLAIMED -> all outputs 0 and priorities back to 1/2. With irq_src_i still high, the source re-pends after reset deasserts.

Source files
------------

// File: rtl/lagarto_plic_target.sv
// PLIC claim/complete controller for a single hart context fed by JTAG0/JTAG1.
// Gateways latch level requests, a registered arbiter drives eip_o, claims/completes serialise service.

package riscv_privileged_pkg;
    localparam int MXLEN = 64;

    typedef logic [MXLEN-1:0] interrupt_priority_t;
    typedef logic [MXLEN-1:0] interrupt_id_t;

    localparam interrupt_id_t       NO_INTERRUPT_ID       = '0;
    localparam interrupt_id_t       JTAG0_ID              = 64'd1;
    localparam interrupt_id_t       JTAG1_ID              = 64'd2;
    localparam interrupt_priority_t NO_INTERRUPT_PRIORITY = '0;
    localparam interrupt_priority_t JTAG0_PRIORITY        = 64'd1;
    localparam interrupt_priority_t JTAG1_PRIORITY        = 64'd2;
    localparam logic [MXLEN-1:0]    INTERRUPT_ENABLE_MASK = 64'h3;
endpackage

module lagarto_plic_target
    import riscv_privileged_pkg::*;
#(
    parameter int NUM_SOURCES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    input  logic                   cfg_we_i,
    input  logic [1:0]             cfg_addr_i,
    input  logic [MXLEN-1:0]       cfg_wdata_i,
    output logic                   eip_o,
    input  logic                   claim_req_i,
    output logic                   claim_valid_o,
    output logic [MXLEN-1:0]       claim_id_o,
    input  logic                   complete_valid_i,
    input  logic [MXLEN-1:0]       complete_id_i
);

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_CLAIMED
    } gw_state_t;

    gw_state_t           r_gw_state [NUM_SOURCES];
    interrupt_priority_t r_prio     [NUM_SOURCES];
    interrupt_priority_t r_threshold;
    logic [NUM_SOURCES-1:0] r_enable;

    interrupt_id_t       r_best_id;
    logic                r_eip;
    logic                r_claim_valid;
    interrupt_id_t       r_claim_id;

    logic [NUM_SOURCES-1:0] w_claim_hit;
    logic [NUM_SOURCES-1:0] w_complete_hit;
    interrupt_id_t          w_next_best;
    interrupt_priority_t    w_best_prio;

    assign eip_o         = r_eip;
    assign claim_valid_o = r_claim_valid;
    assign claim_id_o    = r_claim_id;

    // A source is hit by a claim only when it is the registered winner; a zero
    // best_id matches nothing, so an empty claim leaves every gateway alone.
    always_comb begin
        w_claim_hit    = '0;
        w_complete_hit = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            w_claim_hit[k]    = claim_req_i && (r_best_id == interrupt_id_t'(k + 1));
            w_complete_hit[k] = complete_valid_i && (complete_id_i == interrupt_id_t'(k + 1));
        end
    end

    // Starting from the threshold with a strict compare excludes priority 0 and
    // anything at threshold, and keeps the lowest ID on ties.
    always_comb begin
        w_next_best = NO_INTERRUPT_ID;
        w_best_prio = r_threshold;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if ((r_gw_state[k] == GW_PENDING) && r_enable[k] && !w_claim_hit[k]
                && (r_prio[k] > w_best_prio)) begin
                w_best_prio = r_prio[k];
                w_next_best = interrupt_id_t'(k + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SOURCES; k++) begin
                r_gw_state[k] <= GW_IDLE;
            end
        end else begin
            for (int k = 0; k < NUM_SOURCES; k++) begin
                case (r_gw_state[k])
                    GW_IDLE: begin
                        if (irq_src_i[k]) begin
                            r_gw_state[k] <= GW_PENDING;
                        end
                    end
                    GW_PENDING: begin
                        if (w_claim_hit[k]) begin
                            r_gw_state[k] <= GW_CLAIMED;
                        end
                    end
                    GW_CLAIMED: begin
                        if (w_complete_hit[k]) begin
                            r_gw_state[k] <= GW_IDLE;
                        end
                    end
                    default: begin
                        r_gw_state[k] <= GW_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_threshold <= NO_INTERRUPT_PRIORITY;
            r_enable    <= INTERRUPT_ENABLE_MASK[NUM_SOURCES-1:0];
            for (int k = 0; k < NUM_SOURCES; k++) begin
                if (interrupt_id_t'(k + 1) == JTAG0_ID) begin
                    r_prio[k] <= JTAG0_PRIORITY;
                end else if (interrupt_id_t'(k + 1) == JTAG1_ID) begin
                    r_prio[k] <= JTAG1_PRIORITY;
                end else begin
                    r_prio[k] <= NO_INTERRUPT_PRIORITY;
                end
            end
        end else if (cfg_we_i) begin
            if (cfg_addr_i == 2'd0) begin
                r_threshold <= cfg_wdata_i;
            end else if (cfg_addr_i == 2'd3) begin
                r_enable <= cfg_wdata_i[NUM_SOURCES-1:0];
            end else begin
                for (int k = 0; k < NUM_SOURCES; k++) begin
                    if (int'(cfg_addr_i) == k + 1) begin
                        r_prio[k] <= cfg_wdata_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_best_id <= NO_INTERRUPT_ID;
            r_eip     <= 1'b0;
        end else begin
            r_best_id <= w_next_best;
            r_eip     <= (w_next_best != NO_INTERRUPT_ID);
        end
    end

    // The claim answers with the winner registered before the request edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_claim_valid <= 1'b0;
            r_claim_id    <= NO_INTERRUPT_ID;
        end else begin
            r_claim_valid <= claim_req_i;
            if (claim_req_i) begin
                r_claim_id <= r_best_id;
            end
        end
    end

endmodule

// File: tb/tb_lagarto_plic_target.sv
// Directed self-checking bench for lagarto_plic_target; inputs change and outputs
// are sampled on the falling edge.

module tb_lagarto_plic_target;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  irq_src_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [63:0] cfg_wdata_i;
    logic        eip_o;
    logic        claim_req_i;
    logic        claim_valid_o;
    logic [63:0] claim_id_o;
    logic        complete_valid_i;
    logic [63:0] complete_id_i;

    int tests_run    = 0;
    int tests_failed = 0;

    lagarto_plic_target #(.NUM_SOURCES(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .irq_src_i        (irq_src_i),
        .cfg_we_i         (cfg_we_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_wdata_i      (cfg_wdata_i),
        .eip_o            (eip_o),
        .claim_req_i      (claim_req_i),
        .claim_valid_o    (claim_valid_o),
        .claim_id_o       (claim_id_o),
        .complete_valid_i (complete_valid_i),
        .complete_id_i    (complete_id_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [63:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        step();
        cfg_we_i    = 1'b0;
    endtask

    task automatic complete(input logic [63:0] id);
        complete_valid_i = 1'b1;
        complete_id_i    = id;
        step();
        complete_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_eip: eip_o=%0b expected=0", eip_o);
        end
        tests_run++;
        if (claim_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_claim_valid: claim_valid_o=%0b expected=0", claim_valid_o);
        end
        tests_run++;
        if (claim_id_o !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_claim_id: claim_id_o=%0d expected=0", claim_id_o);
        end
    endtask

    task automatic test_single_source();
        irq_src_i = 2'b01;
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_eip_cycle1: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_eip_cycle2: eip_o=%0b expected=1", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_claim: valid=%0b id=%0d expected valid=1 id=1", claim_valid_o, claim_id_o);
        end
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_eip_after_claim: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (claim_valid_o !== 1'b0 || claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_claim_hold: valid=%0b id=%0d expected valid=0 id=1", claim_valid_o, claim_id_o);
        end
        irq_src_i = 2'b00;
        complete(64'd1);
        step();
    endtask

    task automatic test_back_to_back();
        irq_src_i = 2'b11;
        step();
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_eip: eip_o=%0b expected=1", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: valid=%0b id=%0d expected valid=1 id=2", claim_valid_o, claim_id_o);
        end
        step();
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: valid=%0b id=%0d expected valid=1 id=1", claim_valid_o, claim_id_o);
        end
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_third: valid=%0b id=%0d expected valid=1 id=0", claim_valid_o, claim_id_o);
        end
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_eip_drained: eip_o=%0b expected=0", eip_o);
        end
        irq_src_i = 2'b00;
        complete(64'd1);
        complete(64'd2);
        step();
    endtask

    task automatic test_tie();
        cfg_write(2'd1, 64'd2);
        irq_src_i = 2'b11;
        step();
        step();
        claim_req_i = 1'b1;
        step();
        tests_run++;
        if (claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL tie_lowest_id: id=%0d expected=1", claim_id_o);
        end
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL tie_second: id=%0d expected=2", claim_id_o);
        end
        irq_src_i = 2'b00;
        complete(64'd1);
        complete(64'd2);
        cfg_write(2'd1, 64'd1);
        step();
    endtask

    task automatic test_threshold();
        irq_src_i = 2'b11;
        step();
        step();
        cfg_write(2'd0, 64'd2);
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL thr2_eip: eip_o=%0b expected=0", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL thr2_claim: valid=%0b id=%0d expected valid=1 id=0", claim_valid_o, claim_id_o);
        end
        cfg_write(2'd0, 64'd1);
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL thr1_eip: eip_o=%0b expected=1", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL thr1_claim: id=%0d expected=2", claim_id_o);
        end
        irq_src_i = 2'b00;
        cfg_write(2'd0, 64'd0);
        step();
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL thr0_claim: id=%0d expected=1", claim_id_o);
        end
        complete(64'd1);
        complete(64'd2);
        step();
    endtask

    task automatic test_claim_complete_same_cycle();
        irq_src_i = 2'b11;
        step();
        step();
        claim_req_i = 1'b1;
        step();
        complete_valid_i = 1'b1;
        complete_id_i    = 64'd2;
        step();
        claim_req_i      = 1'b0;
        complete_valid_i = 1'b0;
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_claim: valid=%0b id=%0d expected valid=1 id=1", claim_valid_o, claim_id_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_repend_early: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_repend: eip_o=%0b expected=1", eip_o);
        end
        irq_src_i   = 2'b00;
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_reclaim: id=%0d expected=2", claim_id_o);
        end
        complete(64'd1);
        complete(64'd2);
        step();
    endtask

    task automatic test_claimed_ignores_level();
        irq_src_i = 2'b01;
        step();
        step();
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd1 || eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_claim: id=%0d eip=%0b expected id=1 eip=0", claim_id_o, eip_o);
        end
        step();
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_no_repend: eip_o=%0b expected=0", eip_o);
        end
        complete(64'd2);
        complete(64'd3);
        complete(64'd0);
        step();
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_bad_complete: eip_o=%0b expected=0", eip_o);
        end
        complete(64'd1);
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_complete_edge: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_pending_edge: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_repend_eip: eip_o=%0b expected=1", eip_o);
        end
        irq_src_i   = 2'b00;
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        complete(64'd1);
        step();
    endtask

    task automatic test_reset_mid_claim();
        cfg_write(2'd1, 64'd5);
        irq_src_i = 2'b10;
        step();
        step();
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL midrst_claim: id=%0d expected=2", claim_id_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        tests_run++;
        if (eip_o !== 1'b0 || claim_valid_o !== 1'b0 || claim_id_o !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: eip=%0b valid=%0b id=%0d expected all 0", eip_o, claim_valid_o, claim_id_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_repend_early: eip_o=%0b expected=0", eip_o);
        end
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_repend: eip_o=%0b expected=1", eip_o);
        end
        irq_src_i = 2'b11;
        step();
        step();
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd2) begin
            tests_failed++;
            $display("[TB] FAIL midrst_prio_restored: id=%0d expected=2", claim_id_o);
        end
    endtask

    task automatic test_enable();
        cfg_write(2'd3, 64'd2);
        step();
        tests_run++;
        if (eip_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL enable_off_eip: eip_o=%0b expected=0", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_valid_o !== 1'b1 || claim_id_o !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL enable_off_claim: valid=%0b id=%0d expected valid=1 id=0", claim_valid_o, claim_id_o);
        end
        cfg_write(2'd3, 64'd3);
        step();
        tests_run++;
        if (eip_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL enable_on_eip: eip_o=%0b expected=1", eip_o);
        end
        claim_req_i = 1'b1;
        step();
        claim_req_i = 1'b0;
        tests_run++;
        if (claim_id_o !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL enable_on_claim: id=%0d expected=1", claim_id_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        irq_src_i        = 2'b00;
        cfg_we_i         = 1'b0;
        cfg_addr_i       = 2'd0;
        cfg_wdata_i      = 64'd0;
        claim_req_i      = 1'b0;
        complete_valid_i = 1'b0;
        complete_id_i    = 64'd0;

        test_reset();
        test_single_source();
        test_back_to_back();
        test_tie();
        test_threshold();
        test_claim_complete_same_cycle();
        test_claimed_ignores_level();
        test_reset_mid_claim();
        test_enable();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
